// File: rtl/rnn_cell_mac.sv
// Recurrent-cell engine: h' = act(x*W_ih + h*W_hh) via one sequential fixed-point MAC.
// Define RNN_RELU_EN for ReLU activation; otherwise the saturated result is stored as is.
module rnn_cell_mac #(
    parameter int IN_DIM  = 2,
    parameter int HID_DIM = 4,
    parameter int DATA_W  = 16,
    parameter int FRAC_W  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        irq
);
    localparam int NOPS = IN_DIM + HID_DIM;
    localparam int TW   = $clog2(NOPS);
    localparam int XW   = (IN_DIM  > 1) ? $clog2(IN_DIM)  : 1;
    localparam int JW   = (HID_DIM > 1) ? $clog2(HID_DIM) : 1;
    localparam int PW   = 2 * DATA_W;
    localparam int AW   = PW + TW;

    typedef enum logic [1:0] {IDLE, MAC, COMMIT} state_t;
    typedef logic signed [DATA_W-1:0] elem_t;

    state_t               state_q, state_d;
    logic [JW-1:0]        j_q, j_d;
    logic [TW-1:0]        t_q, t_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic [15:0]          idx_q, idx_d;
    logic [31:0]          dout_q, dout_d;

    elem_t x_q   [IN_DIM];
    elem_t wih_q [IN_DIM][HID_DIM];
    elem_t whh_q [HID_DIM][HID_DIM];
    elem_t h_q   [HID_DIM];
    elem_t hn_q  [HID_DIM];

    logic sel_ok, busy;
    logic wr_ctl, wr_x, wr_ih, wr_hh, wr_idx;
    logic x_ok, ih_ok, hh_ok;
    logic start_go, clr_h, err_set;
    logic x_we, ih_we, hh_we, hn_we, h_commit;

    assign sel_ok   = (addr[31:3] == '0);
    assign busy     = (state_q != IDLE);
    assign wr_ctl   = write && sel_ok && (addr[2:0] == 3'd0);
    assign wr_x     = write && sel_ok && (addr[2:0] == 3'd1);
    assign wr_ih    = write && sel_ok && (addr[2:0] == 3'd2);
    assign wr_hh    = write && sel_ok && (addr[2:0] == 3'd3);
    assign wr_idx   = write && sel_ok && (addr[2:0] == 3'd4);

    assign x_ok  = ({16'b0, data_in[31:16]} < $unsigned(IN_DIM));
    assign ih_ok = ({24'b0, data_in[31:24]} < $unsigned(IN_DIM))
                && ({24'b0, data_in[23:16]} < $unsigned(HID_DIM));
    assign hh_ok = ({24'b0, data_in[31:24]} < $unsigned(HID_DIM))
                && ({24'b0, data_in[23:16]} < $unsigned(HID_DIM));

    assign start_go = wr_ctl && data_in[0] && !busy;
    assign clr_h    = wr_ctl && data_in[1] && !busy;
    assign x_we     = wr_x  && x_ok  && !busy;
    assign ih_we    = wr_ih && ih_ok && !busy;
    assign hh_we    = wr_hh && hh_ok && !busy;
    // A start while busy is silently ignored; only data-path writes and clear-hidden flag err.
    assign err_set  = (wr_ctl && data_in[1] && busy)
                   || (wr_x  && (busy || !x_ok))
                   || (wr_ih && (busy || !ih_ok))
                   || (wr_hh && (busy || !hh_ok));

    logic                 in_phase;
    logic [XW-1:0]        xi;
    logic [JW-1:0]        hk;
    elem_t                op_a, op_b, sat, act;
    logic signed [PW-1:0] prod;
    logic signed [AW-1:0] sum, shifted;
    logic                 pos_ovf, neg_ovf;

    assign in_phase = (t_q < TW'(IN_DIM));
    assign xi       = XW'(t_q);
    assign hk       = JW'(t_q - TW'(IN_DIM));
    assign op_a     = in_phase ? x_q[xi]        : h_q[hk];
    assign op_b     = in_phase ? wih_q[xi][j_q] : whh_q[hk][j_q];
    assign prod     = PW'(op_a) * PW'(op_b);
    assign sum      = acc_q + AW'(prod);
    assign shifted  = sum >>> FRAC_W;
    assign pos_ovf  = !shifted[AW-1] && (|shifted[AW-2:DATA_W-1]);
    assign neg_ovf  = shifted[AW-1] && !(&shifted[AW-2:DATA_W-1]);

    always_comb begin
        sat = shifted[DATA_W-1:0];
        if (pos_ovf) sat = {1'b0, {(DATA_W-1){1'b1}}};
        if (neg_ovf) sat = {1'b1, {(DATA_W-1){1'b0}}};
`ifdef RNN_RELU_EN
        act = sat[DATA_W-1] ? '0 : sat;
`else
        act = sat;
`endif
    end

    always_comb begin
        state_d  = state_q;
        j_d      = j_q;
        t_d      = t_q;
        acc_d    = acc_q;
        done_d   = done_q;
        hn_we    = 1'b0;
        h_commit = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_go) begin
                    state_d = MAC;
                    done_d  = 1'b0;
                    acc_d   = '0;
                    j_d     = '0;
                    t_d     = '0;
                end
            end
            MAC: begin
                if (t_q == TW'(NOPS - 1)) begin
                    hn_we = 1'b1;
                    acc_d = '0;
                    t_d   = '0;
                    if (j_q == JW'(HID_DIM - 1)) state_d = COMMIT;
                    else                         j_d     = j_q + JW'(1);
                end else begin
                    acc_d = sum;
                    t_d   = t_q + TW'(1);
                end
            end
            COMMIT: begin
                h_commit = 1'b1;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    logic [15:0] rb_h;

    always_comb begin
        rb_h = '0;
        if ({16'b0, idx_q} < $unsigned(HID_DIM)) rb_h = 16'(h_q[JW'(idx_q)]);
        idx_d = wr_idx ? data_in[15:0] : idx_q;
        err_d = err_q;
        if (wr_ctl && data_in[2]) err_d = 1'b0;
        if (err_set)              err_d = 1'b1;
        dout_d = dout_q;
        if (read && sel_ok) begin
            case (addr[2:0])
                3'd0:    dout_d = {29'b0, err_q, done_q, busy};
                3'd4:    dout_d = {idx_q, rb_h};
                default: dout_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            j_q     <= '0;
            t_q     <= '0;
            acc_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            j_q     <= j_d;
            t_q     <= t_d;
            acc_q   <= acc_d;
            done_q  <= done_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
            dout_q  <= dout_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q   <= '{default: '0};
            wih_q <= '{default: '0};
            whh_q <= '{default: '0};
            h_q   <= '{default: '0};
            hn_q  <= '{default: '0};
        end else begin
            if (x_we)  x_q[XW'(data_in[31:16])] <= data_in[DATA_W-1:0];
            if (ih_we) wih_q[XW'(data_in[31:24])][JW'(data_in[23:16])] <= data_in[DATA_W-1:0];
            if (hh_we) whh_q[JW'(data_in[31:24])][JW'(data_in[23:16])] <= data_in[DATA_W-1:0];
            if (clr_h) begin
                h_q  <= '{default: '0};
                hn_q <= '{default: '0};
            end else begin
                if (hn_we)    hn_q[j_q] <= act;
                if (h_commit) h_q       <= hn_q;
            end
        end
    end

    assign data_out = dout_q;
    assign irq      = done_q;

endmodule

// File: tb/tb_rnn_cell_mac.sv
// Randomised and directed bench for rnn_cell_mac against an arithmetic reference model.
module tb_rnn_cell_mac;
    localparam int IN_DIM  = 2;
    localparam int HID_DIM = 4;
    localparam int DATA_W  = 16;
    localparam int FRAC_W  = 0;
    localparam int LAT     = HID_DIM * (IN_DIM + HID_DIM) + 1;
    localparam longint MAXV = (longint'(1) <<< (DATA_W - 1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (DATA_W - 1));

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] data_in = '0;
    logic [31:0] data_out;
    logic        irq;

    rnn_cell_mac #(
        .IN_DIM (IN_DIM),
        .HID_DIM(HID_DIM),
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .read    (read),
        .write   (write),
        .addr    (addr),
        .data_in (data_in),
        .data_out(data_out),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    int tick = 0;
    always @(posedge clk) tick <= tick + 1;

    int m_x  [IN_DIM];
    int m_ih [IN_DIM][HID_DIM];
    int m_hh [HID_DIM][HID_DIM];
    int m_h  [HID_DIM];
    int n_checks = 0;
    int n_pass   = 0;

    function automatic int act_sat(input longint s);
        longint r;
        r = s >>> FRAC_W;
        if (r > MAXV) r = MAXV;
        if (r < MINV) r = MINV;
`ifdef RNN_RELU_EN
        if (r < 0) r = 0;
`endif
        return int'(r);
    endfunction

    task automatic model_step(input bit clear);
        int     nh [HID_DIM];
        longint s;
        if (clear) foreach (m_h[k]) m_h[k] = 0;
        for (int j = 0; j < HID_DIM; j++) begin
            s = 0;
            for (int i = 0; i < IN_DIM; i++)  s += longint'(m_x[i]) * longint'(m_ih[i][j]);
            for (int k = 0; k < HID_DIM; k++) s += longint'(m_h[k]) * longint'(m_hh[k][j]);
            nh[j] = act_sat(s);
        end
        m_h = nh;
    endtask

    task automatic model_reset();
        foreach (m_x[i]) m_x[i] = 0;
        foreach (m_ih[i, j]) m_ih[i][j] = 0;
        foreach (m_hh[i, j]) m_hh[i][j] = 0;
        foreach (m_h[k]) m_h[k] = 0;
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a; data_in = d; write = 1'b1;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        addr = a; read = 1'b1;
        @(negedge clk);
        read = 1'b0;
        d = data_out;
    endtask

    task automatic set_x(input int i, input int v);
        bus_wr(32'd1, {16'(i), 16'(v)});
        m_x[i] = v;
    endtask

    task automatic set_ih(input int r, input int c, input int v);
        bus_wr(32'd2, {8'(r), 8'(c), 16'(v)});
        m_ih[r][c] = v;
    endtask

    task automatic set_hh(input int r, input int c, input int v);
        bus_wr(32'd3, {8'(r), 8'(c), 16'(v)});
        m_hh[r][c] = v;
    endtask

    task automatic read_h(input int k, output logic [31:0] d);
        bus_wr(32'd4, 32'(k));
        bus_rd(32'd4, d);
    endtask

    task automatic run_step(input bit clear, output int lat);
        int t0;
        bus_wr(32'd0, clear ? 32'h3 : 32'h1);
        t0 = tick;
        model_step(clear);
        while (irq !== 1'b1 && (tick - t0) < 200) @(negedge clk);
        lat = tick - t0;
    endtask

    task automatic load_plan();
        set_x(0, 2); set_x(1, -3);
        set_ih(0, 0, 2); set_ih(0, 1, -10); set_ih(0, 2, -10); set_ih(0, 3, 3);
        set_ih(1, 0, 6); set_ih(1, 1, 9);   set_ih(1, 2, 12);  set_ih(1, 3, 1);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        n_checks++;
        if (data_out !== 32'h0 || irq !== 1'b0)
            $display("FAIL reset_ports data_out=%h irq=%b required 0/0", data_out, irq);
        else n_pass++;
        bus_rd(32'd0, d);
        n_checks++;
        if (d !== 32'h0) $display("FAIL reset_status got %h required 0", d);
        else n_pass++;
        bus_rd(32'd4, d);
        n_checks++;
        if (d !== 32'h0) $display("FAIL reset_readback got %h required 0", d);
        else n_pass++;
    endtask

    task automatic test_load();
        int          lat;
        logic [31:0] d;
        int          spec_h [HID_DIM];
`ifdef RNN_RELU_EN
        spec_h = '{0, 0, 0, 3};
`else
        spec_h = '{-14, -47, -56, 3};
`endif
        load_plan();
        run_step(1'b0, lat);
        n_checks++;
        if (lat !== LAT) $display("FAIL load_latency got %0d required %0d", lat, LAT);
        else n_pass++;
        bus_rd(32'd0, d);
        n_checks++;
        if (d !== 32'h2) $display("FAIL load_status got %h required 2", d);
        else n_pass++;
        for (int k = 0; k < HID_DIM; k++) begin
            read_h(k, d);
            n_checks++;
            if (d !== {16'(k), 16'(spec_h[k])})
                $display("FAIL load_h%0d got %h required %h", k, d, {16'(k), 16'(spec_h[k])});
            else n_pass++;
        end
    endtask

    task automatic test_readback();
        logic [31:0] d;
        bus_wr(32'd4, 32'd3);
        bus_rd(32'd4, d);
        n_checks++;
        if (d !== 32'h0003_0003) $display("FAIL readback_idx3 got %h required 00030003", d);
        else n_pass++;
        bus_rd(32'd7, d);
        n_checks++;
        if (d !== 32'h0) $display("FAIL readback_addr7 got %h required 0", d);
        else n_pass++;
        bus_rd(32'd0, d);
        bus_rd(32'h10, d);
        n_checks++;
        if (d !== 32'h2) $display("FAIL readback_hiaddr_hold got %h required 2", d);
        else n_pass++;
    endtask

    task automatic test_recurrence();
        int          lat;
        logic [31:0] d;
        int          rows [HID_DIM][HID_DIM];
        rows = '{'{-2, -3, -5, -3}, '{-1, 10, -2, -6}, '{4, 11, 3, -12}, '{-11, -4, 3, -1}};
        foreach (rows[r, c]) set_hh(r, c, rows[r][c]);
        run_step(1'b0, lat);
        n_checks++;
        if (lat !== LAT) $display("FAIL recur_latency got %0d required %0d", lat, LAT);
        else n_pass++;
        for (int k = 0; k < HID_DIM; k++) begin
            read_h(k, d);
            n_checks++;
            if (d !== {16'(k), 16'(m_h[k])})
                $display("FAIL recur_h%0d got %h required %h", k, d, {16'(k), 16'(m_h[k])});
            else n_pass++;
        end
        // Isolate W_hh row 3: clear+start gives h={0,0,0,3}, then step with x=0.
        set_x(0, 1); set_x(1, 0);
        for (int c = 0; c < HID_DIM; c++) begin
            set_ih(0, c, (c == 3) ? 3 : 0);
            set_ih(1, c, 0);
        end
        run_step(1'b1, lat);
        set_x(0, 0);
        run_step(1'b0, lat);
        for (int k = 0; k < HID_DIM; k++) begin
            read_h(k, d);
            n_checks++;
            if (d !== {16'(k), 16'(m_h[k])})
                $display("FAIL whh_row3_h%0d got %h required %h", k, d, {16'(k), 16'(m_h[k])});
            else n_pass++;
        end
    endtask

    task automatic test_saturation();
        int          lat;
        logic [31:0] d;
        set_x(0, 200); set_x(1, -32768);
        for (int c = 0; c < HID_DIM; c++) begin
            set_ih(0, c, (c == 0) ? 200 : 0);
            set_ih(1, c, (c == 1) ? 1 : (c == 2) ? -1 : 0);
        end
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 1) set_ih(0, 0, -200);
            run_step(1'b1, lat);
            for (int k = 0; k < 3; k++) begin
                read_h(k, d);
                n_checks++;
                if (d !== {16'(k), 16'(m_h[k])})
                    $display("FAIL sat%0d_h%0d got %h required %h", pass, k, d, {16'(k), 16'(m_h[k])});
                else n_pass++;
            end
        end
    endtask

    task automatic test_busy_guard();
        int          lat, t0;
        logic [31:0] d;
        foreach (m_x[i]) set_x(i, int'($urandom_range(40)) - 20);
        foreach (m_ih[i, j]) set_ih(i, j, int'($urandom_range(40)) - 20);
        foreach (m_hh[i, j]) set_hh(i, j, int'($urandom_range(40)) - 20);
        bus_wr(32'd0, 32'h1);
        t0 = tick;
        model_step(1'b0);
        bus_rd(32'd0, d);
        n_checks++;
        if (d !== 32'h1) $display("FAIL busy_status got %h required 1", d);
        else n_pass++;
        bus_wr(32'd0, 32'h1);
        bus_rd(32'd0, d);
        n_checks++;
        if (d !== 32'h1) $display("FAIL busy_start_no_err got %h required 1", d);
        else n_pass++;
        bus_wr(32'd2, {8'd0, 8'd0, 16'd1234});
        bus_wr(32'd1, {16'd9, 16'd5});
        bus_wr(32'd3, {8'd1, 8'd1, 16'd77});
        bus_wr(32'd0, 32'h2);
        while (irq !== 1'b1 && (tick - t0) < 200) @(negedge clk);
        lat = tick - t0;
        n_checks++;
        if (lat !== LAT) $display("FAIL busy_latency got %0d required %0d", lat, LAT);
        else n_pass++;
        bus_rd(32'd0, d);
        n_checks++;
        if (d !== 32'h6) $display("FAIL busy_err_set got %h required 6", d);
        else n_pass++;
        for (int k = 0; k < HID_DIM; k++) begin
            read_h(k, d);
            n_checks++;
            if (d !== {16'(k), 16'(m_h[k])})
                $display("FAIL busy_h%0d got %h required %h", k, d, {16'(k), 16'(m_h[k])});
            else n_pass++;
        end
        run_step(1'b0, lat);
        for (int k = 0; k < HID_DIM; k++) begin
            read_h(k, d);
            n_checks++;
            if (d !== {16'(k), 16'(m_h[k])})
                $display("FAIL busy_weights_h%0d got %h required %h", k, d, {16'(k), 16'(m_h[k])});
            else n_pass++;
        end
        bus_wr(32'd0, 32'h4);
        bus_rd(32'd0, d);
        n_checks++;
        if (d !== 32'h2) $display("FAIL clear_err got %h required 2", d);
        else n_pass++;
        bus_wr(32'd2, {8'd2, 8'd0, 16'd7});
        bus_rd(32'd0, d);
        n_checks++;
        if (d !== 32'h6) $display("FAIL range_err_ih got %h required 6", d);
        else n_pass++;
        bus_wr(32'd0, 32'h4);
        bus_wr(32'd3, {8'd3, 8'd3, 16'(m_hh[3][3])});
        bus_rd(32'd0, d);
        n_checks++;
        if (d !== 32'h2) $display("FAIL inrange_no_err got %h required 2", d);
        else n_pass++;
    endtask

    task automatic test_reset_mid_step();
        int          lat;
        logic [31:0] d;
        bus_wr(32'd0, 32'h1);
        bus_rd(32'd0, d);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (data_out !== 32'h0 || irq !== 1'b0)
            $display("FAIL midreset_ports data_out=%h irq=%b required 0/0", data_out, irq);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        bus_rd(32'd0, d);
        n_checks++;
        if (d !== 32'h0) $display("FAIL midreset_status got %h required 0", d);
        else n_pass++;
        read_h(3, d);
        n_checks++;
        if (d !== 32'h0003_0000) $display("FAIL midreset_h3 got %h required 00030000", d);
        else n_pass++;
        load_plan();
        run_step(1'b0, lat);
        n_checks++;
        if (lat !== LAT) $display("FAIL midreset_latency got %0d required %0d", lat, LAT);
        else n_pass++;
        for (int k = 0; k < HID_DIM; k++) begin
            read_h(k, d);
            n_checks++;
            if (d !== {16'(k), 16'(m_h[k])})
                $display("FAIL midreset_h%0d got %h required %h", k, d, {16'(k), 16'(m_h[k])});
            else n_pass++;
        end
    endtask

    task automatic test_random();
        int          lat;
        bit          clr;
        logic [31:0] d;
        for (int it = 0; it < 6; it++) begin
            foreach (m_x[i]) set_x(i, int'($urandom_range(800)) - 400);
            foreach (m_ih[i, j]) set_ih(i, j, int'($urandom_range(800)) - 400);
            foreach (m_hh[i, j]) set_hh(i, j, int'($urandom_range(800)) - 400);
            clr = 1'($urandom_range(1));
            run_step(clr, lat);
            n_checks++;
            if (lat !== LAT) $display("FAIL rand%0d_latency got %0d required %0d", it, lat, LAT);
            else n_pass++;
            for (int k = 0; k < HID_DIM; k++) begin
                read_h(k, d);
                n_checks++;
                if (d !== {16'(k), 16'(m_h[k])})
                    $display("FAIL rand%0d_h%0d got %h required %h", it, k, d, {16'(k), 16'(m_h[k])});
                else n_pass++;
            end
        end
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_load();
        test_readback();
        test_recurrence();
        test_saturation();
        test_busy_guard();
        test_reset_mid_step();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
